// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the 5-stage pipeline front end: branch type, LEGv8 condition
// codes, branch-resolve FSM state and a bundle for the NZVC flags.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // ID-stage branch classification (brType encoding)
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_CBZ  = 2'b10,
        BR_COND = 2'b11
    } br_type_t;

    // LEGv8 condition codes. Bit 0 inverts the sense of the even code, except
    // for AL/NV which are both "always".
    typedef enum logic [3:0] {
        C_EQ = 4'b0000, C_NE = 4'b0001,
        C_HS = 4'b0010, C_LO = 4'b0011,
        C_MI = 4'b0100, C_PL = 4'b0101,
        C_VS = 4'b0110, C_VC = 4'b0111,
        C_HI = 4'b1000, C_LS = 4'b1001,
        C_GE = 4'b1010, C_LT = 4'b1011,
        C_GT = 4'b1100, C_LE = 4'b1101,
        C_AL = 4'b1110, C_NV = 4'b1111
    } cond_t;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } br_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

    // Flags seen by ID: a flag-setting EX instruction overrides the latched
    // register in the same cycle, so the branch never sees stale flags.
    function automatic nzvc_t sel_flags(input logic  ex_set,
                                        input nzvc_t ex_f,
                                        input nzvc_t reg_f);
        return ex_set ? ex_f : reg_f;
    endfunction

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational LEGv8 condition evaluator. Kept standalone so later
// conditional-select logic can reuse the same decode.
//   i_cond           : 4-bit condition code
//   i_n,i_z,i_v,i_c  : effective flags
//   o_true           : condition holds
// -----------------------------------------------------------------------------
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_v,
    input  logic       i_c,
    output logic       o_true
);

    logic w_base;
    logic w_always;

    // Evaluate the even (positive) code of each pair; bit 0 inverts it.
    always_comb begin
        w_base = 1'b0;
        unique case (i_cond[3:1])
            3'b000:  w_base = i_z;                    // EQ / NE
            3'b001:  w_base = i_c;                    // HS / LO
            3'b010:  w_base = i_n;                    // MI / PL
            3'b011:  w_base = i_v;                    // VS / VC
            3'b100:  w_base = i_c & ~i_z;             // HI / LS
            3'b101:  w_base = (i_n == i_v);           // GE / LT
            3'b110:  w_base = ~i_z & (i_n == i_v);    // GT / LE
            3'b111:  w_base = 1'b1;                   // AL / NV
            default: w_base = 1'b0;
        endcase
    end

    // NV is not the inverse of AL: both are unconditionally true.
    assign w_always = (i_cond[3:1] == 3'b111);
    assign o_true   = w_always ? 1'b1 : (w_base ^ i_cond[0]);

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// ID-stage conditional-branch resolution. Evaluates B / CBZ / B.cond with the
// effective NZVC flags (EX-forwarded when EX sets flags this cycle), and on a
// taken branch registers a one-cycle PC redirect plus IF/ID flush. The cycle
// after a redirect holds a wrong-path instruction and is ignored. Saturating
// branch / taken counters are kept for performance debug.
//   clk, reset          : clock, async active-low reset
//   valid_id, stall     : ID holds a real instruction / hazard stall
//   brType, cond        : branch kind and LEGv8 condition
//   pc, imm, rtZero     : ID PC, word offset, CBZ operand-is-zero
//   *_flag              : latched NZVC
//   ex_*, ex_SInstr     : live EX flags and their enable
//   pcSrc, brTarget     : registered redirect and target
//   flush_ifid          : registered IF/ID squash
//   br_count, taken_count : saturating statistics
// -----------------------------------------------------------------------------
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_id,
    input  logic              stall,
    input  logic [1:0]        brType,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic              rtZero,
    input  logic              negative_flag,
    input  logic              zero_flag,
    input  logic              overflow_flag,
    input  logic              carry_out_flag,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_overflow,
    input  logic              ex_carry_out,
    input  logic              ex_SInstr,
    output logic              pcSrc,
    output logic [ADDR_W-1:0] brTarget,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    br_state_t         r_state;
    logic              r_pcsrc;
    logic              r_flush;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_tk_cnt;

    nzvc_t             w_flags;
    br_type_t          w_type;
    logic              w_cond_true;
    logic              w_taken;
    logic              w_resolve;
    logic              w_take_now;
    logic [ADDR_W-1:0] w_target;

    // Flag-forward mux: no added latency, chosen per cycle.
    assign w_flags = sel_flags(ex_SInstr,
                               '{n: ex_negative, z: ex_zero,
                                 v: ex_overflow, c: ex_carry_out},
                               '{n: negative_flag, z: zero_flag,
                                 v: overflow_flag, c: carry_out_flag});

    cond_eval u_cond (
        .i_cond (cond),
        .i_n    (w_flags.n),
        .i_z    (w_flags.z),
        .i_v    (w_flags.v),
        .i_c    (w_flags.c),
        .o_true (w_cond_true)
    );

    assign w_type = br_type_t'(brType);

    always_comb begin
        w_taken = 1'b0;
        unique case (w_type)
            BR_B:    w_taken = 1'b1;
            BR_CBZ:  w_taken = rtZero;
            BR_COND: w_taken = w_cond_true;
            default: w_taken = 1'b0;
        endcase
    end

    // Target wraps modulo 2^ADDR_W; the shift drops imm's top two bits.
    assign w_target = pc + (imm << 2);

    // Only IDLE may resolve: the ID slot during REDIRECT is wrong-path.
    assign w_resolve  = (r_state == S_IDLE) & valid_id & ~stall &
                        (w_type != BR_NONE);
    assign w_take_now = w_resolve & w_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pcsrc  <= 1'b0;
            r_flush  <= 1'b0;
            r_target <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take_now) begin
                        r_state  <= S_REDIRECT;
                        r_pcsrc  <= 1'b1;
                        r_flush  <= 1'b1;
                        r_target <= w_target;
                    end else begin
                        r_pcsrc  <= 1'b0;
                        r_flush  <= 1'b0;
                    end
                end
                S_REDIRECT: begin
                    r_state <= S_IDLE;
                    r_pcsrc <= 1'b0;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pcsrc <= 1'b0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_br_cnt <= '0;
            r_tk_cnt <= '0;
        end else begin
            if (w_resolve && (r_br_cnt != '1))
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_take_now && (r_tk_cnt != '1))
                r_tk_cnt <= r_tk_cnt + CNT_W'(1);
        end
    end

    assign pcSrc       = r_pcsrc;
    assign flush_ifid  = r_flush;
    assign brTarget    = r_target;
    assign br_count    = r_br_cnt;
    assign taken_count = r_tk_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
    localparam int AW = 64;
    localparam int CW = 4;   // small so saturation is reached quickly

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_id, stall, rtZero, ex_SInstr;
    logic [1:0]    brType;
    logic [3:0]    cond;
    logic [AW-1:0] pc, imm;
    logic          negative_flag, zero_flag, overflow_flag, carry_out_flag;
    logic          ex_negative, ex_zero, ex_overflow, ex_carry_out;
    logic          pcSrc, flush_ifid;
    logic [AW-1:0] brTarget;
    logic [CW-1:0] br_count, taken_count;

    branch_resolve #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .stall(stall),
        .brType(brType), .cond(cond), .pc(pc), .imm(imm), .rtZero(rtZero),
        .negative_flag(negative_flag), .zero_flag(zero_flag),
        .overflow_flag(overflow_flag), .carry_out_flag(carry_out_flag),
        .ex_negative(ex_negative), .ex_zero(ex_zero),
        .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
        .ex_SInstr(ex_SInstr), .pcSrc(pcSrc), .brTarget(brTarget),
        .flush_ifid(flush_ifid), .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, st, rz, si;
        bit [1:0]    bt;
        bit [3:0]    cc, lf, ef;   // flags packed as {N,Z,V,C}
        bit [AW-1:0] pc, imm;
    } stim_t;

    typedef struct {
        bit          pcs, fl;
        bit [AW-1:0] tgt;
        int          br, tk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference state
    bit          m_redir;
    bit [AW-1:0] m_tgt;
    int          m_br, m_tk;
    localparam int SAT = (1 << CW) - 1;

    task automatic chk(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input int c, input bit n, input bit z,
                                    input bit v, input bit cy);
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !(cy && !z);
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return !(!z && (n == v));
            default: return 1'b1;   // AL, NV
        endcase
    endfunction

    function automatic void model_reset();
        m_redir = 0; m_tgt = '0; m_br = 0; m_tk = 0;
    endfunction

    // Apply one cycle of stimulus, update the reference at the edge, queue
    // what the outputs must show during the following cycle.
    task automatic step(input stim_t s);
        bit [3:0] f;
        bit res, tk;
        exp_t e;
        valid_id = s.v; stall = s.st; brType = s.bt; cond = s.cc;
        pc = s.pc; imm = s.imm; rtZero = s.rz; ex_SInstr = s.si;
        {negative_flag, zero_flag, overflow_flag, carry_out_flag} = s.lf;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = s.ef;
        @(posedge clk);
        f   = s.si ? s.ef : s.lf;
        res = !m_redir && s.v && !s.st && (s.bt != 2'd0);
        tk  = 0;
        if (res) begin
            if (s.bt == 2'd1) tk = 1;
            else if (s.bt == 2'd2) tk = s.rz;
            else tk = ref_cond(int'(s.cc), f[3], f[2], f[1], f[0]);
        end
        if (res && m_br < SAT) m_br++;
        if (tk && m_tk < SAT) m_tk++;
        if (tk) m_tgt = s.pc + s.imm * 64'd4;
        m_redir = tk;
        e.pcs = tk; e.fl = tk; e.tgt = m_tgt; e.br = m_br; e.tk = m_tk;
        q.push_back(e);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.st = 0; s.rz = 0; s.si = 0; s.bt = 0; s.cc = 0;
        s.lf = 0; s.ef = 0; s.pc = 0; s.imm = 0;
        return s;
    endfunction

    function automatic stim_t br(input bit [1:0] bt, input bit [3:0] cc,
                                 input bit [AW-1:0] p, input bit [AW-1:0] im);
        stim_t s = idle();
        s.v = 1; s.bt = bt; s.cc = cc; s.pc = p; s.imm = im;
        return s;
    endfunction

    // Monitor: each falling edge the registered outputs reflect the last edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcSrc", AW'(pcSrc), AW'(e.pcs));
                chk("flush_ifid", AW'(flush_ifid), AW'(e.fl));
                chk("brTarget", brTarget, e.tgt);
                chk("br_count", AW'(br_count), AW'(e.br));
                chk("taken_count", AW'(taken_count), AW'(e.tk));
            end
        end
    end

    initial begin
        stim_t s;
        reset = 0;
        void'(idle());
        s = idle();
        valid_id = 0; stall = 0; brType = 0; cond = 0; pc = 0; imm = 0;
        rtZero = 0; ex_SInstr = 0;
        {negative_flag, zero_flag, overflow_flag, carry_out_flag} = 4'h0;
        {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'h0;
        model_reset();
        #1;
        chk("rst_pcSrc", AW'(pcSrc), '0);
        chk("rst_flush", AW'(flush_ifid), '0);
        chk("rst_target", brTarget, '0);
        chk("rst_brcnt", AW'(br_count), '0);
        chk("rst_tkcnt", AW'(taken_count), '0);
        repeat (2) @(negedge clk);
        #2 reset = 1;

        // B pc=0x100 imm=4 -> target 0x110
        step(br(2'd1, 4'h0, 64'h100, 64'd4));
        #3 chk("first_target", brTarget, 64'h110);
        step(idle());
        step(idle());

        // Forwarded Z from EX makes B.EQ taken; latched Z alone does not
        s = br(2'd3, 4'h0, 64'h200, 64'd8); s.lf = 4'b0000; s.ef = 4'b0100; s.si = 1;
        step(s); step(idle());
        s.si = 0;
        step(s); step(idle());

        // Full 16x16 condition sweep
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++) begin
                s = br(2'd3, c[3:0], 64'h1000 + 64'(c * 64), 64'(f) - 64'd8);
                s.lf = f[3:0];
                step(s); step(idle());
            end

        model_reset();
        reset = 0; #1 reset = 1;   // counters back to 0 for the next patterns
        q.delete();

        // Taken CBZ followed immediately by B in the REDIRECT slot
        s = br(2'd2, 4'h0, 64'h300, 64'hFFFF_FFFF_FFFF_FFFC); s.rz = 1;
        step(s);
        step(br(2'd1, 4'h0, 64'h304, 64'd100));
        step(idle());

        // Stalled B.cond for three cycles, flags change on release cycle
        s = br(2'd3, 4'hA, 64'h400, 64'd3); s.st = 1; s.lf = 4'b1000;
        repeat (3) step(s);
        s.st = 0; s.lf = 4'b1001;
        step(s); step(idle());

        // Target wrap
        step(br(2'd1, 4'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8)); step(idle());

        // Randomized traffic, pushes both counters into saturation
        for (int i = 0; i < 400; i++) begin
            s.v  = ($urandom_range(0, 9) != 0);
            s.st = ($urandom_range(0, 3) == 0);
            s.bt = 2'($urandom_range(0, 3));
            s.cc = 4'($urandom_range(0, 15));
            s.rz = 1'($urandom);
            s.si = 1'($urandom);
            s.lf = 4'($urandom);
            s.ef = 4'($urandom);
            s.pc = {$urandom, $urandom};
            s.imm = {$urandom, $urandom};
            step(s);
        end
        step(idle());

        // Saturated counters with a further taken branch: both hold
        step(br(2'd1, 4'h0, 64'h500, 64'd1)); step(idle());
        @(negedge clk); #1;
        chk("sat_brcnt", AW'(br_count), AW'(SAT));
        chk("sat_tkcnt", AW'(taken_count), AW'(SAT));

        // Async reset in the middle of a REDIRECT cycle
        step(br(2'd1, 4'h0, 64'h600, 64'd2));
        #1 chk("pre_rst_pcSrc", AW'(pcSrc), AW'(1));
        reset = 0;
        q.delete();
        model_reset();
        #1;
        chk("midrst_pcSrc", AW'(pcSrc), '0);
        chk("midrst_flush", AW'(flush_ifid), '0);
        chk("midrst_brcnt", AW'(br_count), '0);
        chk("midrst_tkcnt", AW'(taken_count), '0);
        @(negedge clk); #2 reset = 1;
        step(idle()); step(idle());

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", AW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
